max_pool2d_stream: RTL and testbench

Parametrised 2-D max-pooling stage for the CNN datapath, generalising the 1-D multi-channel row pooler. Accepts one feature-map row per valid cycle for all channels in parallel, reduces each POOL×POOL window to its maximum, and emits one output row per POOL input rows. Elements are IEEE-754 single-precision patterns compared as sign-magnitude values. Tracks frame position and flags the last output row of each frame.

---
 rtl/max_pool2d_stream.sv | 133 +++++++++++++
 tb/tb_max_pool2d_stream.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/max_pool2d_stream.sv
// Streaming 2-D max pooling over float32 bit patterns.
// A row for every channel arrives in one beat. Each row is reduced horizontally,
// and rows are then combined vertically. One output row is produced for every POOL
// input rows, and frame position is tracked so the last output row is flagged.
module max_pool2d_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CHANNELS   = 4,
  parameter int unsigned IN_W       = 92,
  parameter int unsigned IN_H       = 92,
  parameter int unsigned POOL       = 2,
  localparam int unsigned OUT_W     = IN_W / POOL,
  localparam int unsigned OUT_H     = IN_H / POOL,
  localparam int unsigned RW        = ($clog2(OUT_H) > 1) ? $clog2(OUT_H) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 valid_i,
  input  logic                                 sof_i,
  input  logic [CHANNELS*IN_W*DATA_WIDTH-1:0]  multi_input_data,
  output logic                                 valid_o,
  output logic [CHANNELS*OUT_W*DATA_WIDTH-1:0] multi_output_data,
  output logic [RW-1:0]                        out_row_o,
  output logic                                 eof_o
);

  localparam int unsigned IRW       = ($clog2(IN_H) > 1) ? $clog2(IN_H) : 1;
  localparam int unsigned WW        = $clog2(POOL);
  localparam int unsigned NELEM     = CHANNELS * OUT_W;
  localparam int unsigned ROW_BITS  = NELEM * DATA_WIDTH;
  localparam int unsigned ROWS_USED = OUT_H * POOL;

  logic [IRW-1:0]        in_row;
  logic [WW-1:0]         win_row;
  logic [RW-1:0]         out_row;
  logic [ROW_BITS-1:0]   acc;
  logic [ROW_BITS-1:0]   h_row;
  logic [ROW_BITS-1:0]   v_row;
  logic [DATA_WIDTH-1:0] hm;

  logic                  start_c;
  logic                  used_c;
  logic                  win_last_c;
  logic [IRW-1:0]        eff_in_c;
  logic [WW-1:0]         eff_win_c;
  logic [RW-1:0]         eff_out_c;
  logic [IRW-1:0]        in_row_nxt_c;
  logic [RW-1:0]         out_row_nxt_c;

  // Sign-magnitude maximum. Equal patterns return a, and +0 beats -0.
  function automatic logic [DATA_WIDTH-1:0] fmax(input logic [DATA_WIDTH-1:0] a,
                                                 input logic [DATA_WIDTH-1:0] b);
    logic sa;
    logic sb;
    sa = a[DATA_WIDTH-1];
    sb = b[DATA_WIDTH-1];
    if (sa != sb)
      fmax = sa ? b : a;
    else if (!sa)
      fmax = (b[DATA_WIDTH-2:0] > a[DATA_WIDTH-2:0]) ? b : a;
    else
      fmax = (b[DATA_WIDTH-2:0] < a[DATA_WIDTH-2:0]) ? b : a;
  endfunction

  // Horizontal reduction: each group of POOL adjacent columns collapses to its maximum.
  always_comb begin
    h_row = '0;
    hm    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned k = 0; k < OUT_W; k++) begin
        hm = multi_input_data[(c*IN_W + k*POOL)*DATA_WIDTH +: DATA_WIDTH];
        for (int unsigned p = 1; p < POOL; p++)
          hm = fmax(hm, multi_input_data[(c*IN_W + k*POOL + p)*DATA_WIDTH +: DATA_WIDTH]);
        h_row[(c*OUT_W + k)*DATA_WIDTH +: DATA_WIDTH] = hm;
      end
    end
  end

  // Vertical merge of the running window maximum with the current reduced row.
  always_comb begin
    v_row = '0;
    for (int unsigned i = 0; i < NELEM; i++)
      v_row[i*DATA_WIDTH +: DATA_WIDTH] = fmax(acc[i*DATA_WIDTH +: DATA_WIDTH],
                                               h_row[i*DATA_WIDTH +: DATA_WIDTH]);
  end

  // Effective position of the incoming row. A start-of-frame row forces the position to row 0.
  always_comb begin
    start_c       = valid_i & sof_i;
    eff_in_c      = start_c ? '0 : in_row;
    eff_win_c     = start_c ? '0 : win_row;
    eff_out_c     = start_c ? '0 : out_row;
    used_c        = (32'(eff_in_c) < ROWS_USED);
    win_last_c    = (eff_win_c == WW'(POOL - 1));
    in_row_nxt_c  = (eff_in_c == IRW'(IN_H - 1)) ? '0 : eff_in_c + IRW'(1);
    out_row_nxt_c = (eff_out_c == RW'(OUT_H - 1)) ? '0 : eff_out_c + RW'(1);
  end

  // Row counters, window accumulator and the registered output row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_row            <= '0;
      win_row           <= '0;
      out_row           <= '0;
      acc               <= '0;
      valid_o           <= 1'b0;
      eof_o             <= 1'b0;
      out_row_o         <= '0;
      multi_output_data <= '0;
    end else begin
      valid_o <= 1'b0;
      eof_o   <= 1'b0;
      if (valid_i) begin
        in_row  <= in_row_nxt_c;
        win_row <= eff_win_c;
        out_row <= eff_out_c;
        if (used_c) begin
          acc <= (eff_win_c == '0) ? h_row : v_row;
          if (win_last_c) begin
            multi_output_data <= v_row;
            out_row_o         <= eff_out_c;
            valid_o           <= 1'b1;
            eof_o             <= (eff_out_c == RW'(OUT_H - 1));
            out_row           <= out_row_nxt_c;
            win_row           <= '0;
          end else begin
            win_row <= eff_win_c + WW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_max_pool2d_stream.sv
// Directed bench for max_pool2d_stream.
// Geometry: 2 channels, 5x5 input, 2x2 pooling. This gives a 2x2 output.
// Column 4 and row 4 of each frame are not used by any output.
module tb_max_pool2d_stream;

  localparam int unsigned DW    = 32;
  localparam int unsigned CH    = 2;
  localparam int unsigned IW    = 5;
  localparam int unsigned IH    = 5;
  localparam int unsigned PL    = 2;
  localparam int unsigned OW    = IW / PL;
  localparam int unsigned IBITS = CH * IW * DW;
  localparam int unsigned OBITS = CH * OW * DW;

  logic             clk = 1'b0;
  logic             reset;
  logic             valid_i;
  logic             sof_i;
  logic [IBITS-1:0] din;
  logic [OBITS-1:0] dout;
  logic             valid_o;
  logic [0:0]       out_row_o;
  logic             eof_o;

  int checks = 0;
  int errors = 0;

  max_pool2d_stream #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .IN_W       (IW),
    .IN_H       (IH),
    .POOL       (PL)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .valid_i           (valid_i),
    .sof_i             (sof_i),
    .multi_input_data  (din),
    .valid_o           (valid_o),
    .multi_output_data (dout),
    .out_row_o         (out_row_o),
    .eof_o             (eof_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OBITS-1:0] obs, input logic [OBITS-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Builds a row where each column pair holds (a,b) in channel 0 and (b,a) in channel 1.
  // Column 4 holds a large positive value and must be ignored.
  function automatic logic [IBITS-1:0] fill(input logic [31:0] a, input logic [31:0] b);
    logic [IBITS-1:0] r;
    r = '0;
    for (int c = 0; c < int'(CH); c++)
      for (int j = 0; j < int'(IW); j++)
        r[(c*IW + j)*DW +: DW] = (j == 4) ? 32'h7F7FFFFF :
                                 (((j % 2) == 0) ^ (c == 1)) ? a : b;
    return r;
  endfunction

  function automatic logic [OBITS-1:0] rep(input logic [31:0] v);
    return {(OBITS/DW){v}};
  endfunction

  task automatic step(input logic v, input logic s, input logic [IBITS-1:0] d);
    @(negedge clk);
    valid_i = v;
    sof_i   = s;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rv;
    logic        ev;
    logic        er;
    reset   = 1'b1;
    valid_i = 1'b0;
    sof_i   = 1'b0;
    din     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", OBITS'(valid_o), OBITS'(1'b0));
    check("rst_eof", OBITS'(eof_o), OBITS'(1'b0));
    check("rst_data", dout, '0);
    check("rst_row", OBITS'(out_row_o), OBITS'(1'b0));
    @(negedge clk);
    reset = 1'b0;

    // Test 1: sign comparison. The negative value 0x8C000000 loses to the positive value 0x0C000000.
    step(1'b1, 1'b0, fill(32'h8C000000, 32'h0C000000));
    check("t1_row0_valid", OBITS'(valid_o), OBITS'(1'b0));
    step(1'b1, 1'b0, fill(32'h8C000000, 32'h0C000000));
    check("t1_valid", OBITS'(valid_o), OBITS'(1'b1));
    check("t1_data", dout, rep(32'h0C000000));
    check("t1_row", OBITS'(out_row_o), OBITS'(1'b0));
    check("t1_eof", OBITS'(eof_o), OBITS'(1'b0));
    step(1'b0, 1'b0, din);
    check("t1_pulse_end", OBITS'(valid_o), OBITS'(1'b0));

    // Test 2: negative ordering. -0 wins over -1, -2 and -3; +0 wins over all of them.
    step(1'b1, 1'b1, fill(32'hC0000000, 32'hBF800000));
    step(1'b1, 1'b0, fill(32'hC0400000, 32'h80000000));
    check("t2_valid", OBITS'(valid_o), OBITS'(1'b1));
    check("t2_negzero", dout, rep(32'h80000000));
    check("t2_row0", OBITS'(out_row_o), OBITS'(1'b0));
    step(1'b1, 1'b0, fill(32'hC0000000, 32'hBF800000));
    step(1'b1, 1'b0, fill(32'hC0400000, 32'h00000000));
    check("t2_poszero", dout, rep(32'h00000000));
    check("t2_row1", OBITS'(out_row_o), OBITS'(1'b1));
    check("t2_eof", OBITS'(eof_o), OBITS'(1'b1));

    // Test 3: idle gaps inside a window. The output pulse appears exactly once and the data is then held.
    step(1'b1, 1'b1, fill(32'h40400000, 32'h40400000));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, fill(32'h7F000000, 32'h7F000000));
      check("t3_gap_valid", OBITS'(valid_o), OBITS'(1'b0));
    end
    step(1'b1, 1'b0, fill(32'h3F800000, 32'h3F800000));
    check("t3_valid", OBITS'(valid_o), OBITS'(1'b1));
    check("t3_data", dout, rep(32'h40400000));
    step(1'b0, 1'b0, din);
    check("t3_pulse_end", OBITS'(valid_o), OBITS'(1'b0));
    check("t3_hold", dout, rep(32'h40400000));

    // Test 4: two frames back to back (10 rows). Row 4 of each frame is a trailing row and is discarded.
    for (int r = 1; r <= 10; r++) begin
      rv = (r == 5 || r == 10) ? 32'h7F000000 : 32'h40000000 + 32'(r);
      step(1'b1, (r == 1), fill(rv, rv));
      ev = (r == 2 || r == 4 || r == 7 || r == 9);
      er = (r == 4 || r == 9);
      check($sformatf("t4_valid_r%0d", r), OBITS'(valid_o), OBITS'(ev));
      check($sformatf("t4_eof_r%0d", r), OBITS'(eof_o), OBITS'(ev & er));
      if (ev) begin
        check($sformatf("t4_data_r%0d", r), dout, rep(32'h40000000 + 32'(r)));
        check($sformatf("t4_row_r%0d", r), OBITS'(out_row_o), OBITS'(er));
      end
    end

    // Test 5: sof_i in the middle of a window discards the partial window.
    step(1'b1, 1'b0, fill(32'h40000000, 32'h40000000));
    step(1'b1, 1'b1, fill(32'h3F800000, 32'h3F800000));
    check("t5_no_early", OBITS'(valid_o), OBITS'(1'b0));
    step(1'b1, 1'b0, fill(32'h3F000000, 32'h3F000000));
    check("t5_valid", OBITS'(valid_o), OBITS'(1'b1));
    check("t5_data", dout, rep(32'h3F800000));
    check("t5_row", OBITS'(out_row_o), OBITS'(1'b0));

    // Test 6: asynchronous reset after one row of the frame's second window.
    step(1'b1, 1'b0, fill(32'h42000000, 32'h42000000));
    #2 reset = 1'b1;
    #1;
    check("t6_async_data", dout, '0);
    check("t6_async_valid", OBITS'(valid_o), OBITS'(1'b0));
    step(1'b0, 1'b0, din);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, fill(32'h41200000, 32'h41200000));
    check("t6_no_early", OBITS'(valid_o), OBITS'(1'b0));
    step(1'b1, 1'b0, fill(32'h41200000, 32'h41200000));
    check("t6_valid", OBITS'(valid_o), OBITS'(1'b1));
    check("t6_data", dout, rep(32'h41200000));
    check("t6_row", OBITS'(out_row_o), OBITS'(1'b0));
    check("t6_eof", OBITS'(eof_o), OBITS'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
